// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch / load-store memory port arbiter: FSM state encoding,
// grant selection and the default byte-enable constant for 32-bit data.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_DROP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_sel_e;

  localparam int unsigned ARB_DATA_W = 32;
  localparam logic [ARB_DATA_W/8-1:0] DEFAULT_MASK = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// Handshake: a requester raises *_request with stable fields and holds them until
// its one-cycle *_valid pulse; memory sees a one-cycle mem_req and answers with a
// one-cycle mem_valid some later cycle. There is no ready; at most one transaction
// is outstanding.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              if_request;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_request;
  logic              d_we;
  logic [MASK_W-1:0] d_mask;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [MASK_W-1:0] mem_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              timeout;

  modport master (
    input  if_request, if_addr, if_flush,
    input  d_request, d_we, d_mask, d_addr, d_wdata,
    input  mem_valid, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata,
    output mem_req, mem_we, mem_mask, mem_addr, mem_wdata, timeout
  );

  modport slave (
    output if_request, if_addr, if_flush,
    output d_request, d_we, d_mask, d_addr, d_wdata,
    output mem_valid, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata,
    input  mem_req, mem_we, mem_mask, mem_addr, mem_wdata, timeout
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data grants handed out while fetch was waiting; starved_o
// tells the arbiter that fetch must win the next contested grant.
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic starved_o
);
  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q >= CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between fetch and load/store, one transaction
// at a time, with fetch-flush dropping and a no-response timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus,
  output arb_state_e           dbg_state_o
);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MASK_W-1:0] mem_mask_q, mem_mask_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              timeout_q, timeout_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic     starved;
  logic     d_wins;
  logic     if_wins;
  logic     grant;
  gnt_sel_e gnt_sel;
  logic     tmo_hit;

  // Data normally wins; fetch only wins when data is absent or fetch is starved.
  assign d_wins  = bus.d_request && (!starved || !bus.if_request);
  assign if_wins = bus.if_request && !d_wins;
  assign gnt_sel = d_wins ? GNT_D : GNT_IF;
  assign grant   = (state_q == ST_IDLE) && (d_wins || if_wins);
  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT - 1));

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (grant && (gnt_sel == GNT_D) && bus.if_request),
    .clr_i     (grant && ((gnt_sel == GNT_IF) || !bus.if_request)),
    .starved_o (starved)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_mask_d  = mem_mask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    timeout_d   = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        if (grant) begin
          mem_req_d = 1'b1;
          if (gnt_sel == GNT_D) begin
            state_d     = ST_BUSY_D;
            mem_we_d    = bus.d_we;
            mem_mask_d  = bus.d_mask;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            state_d     = ST_BUSY_IF;
            mem_we_d    = 1'b0;
            mem_mask_d  = '1;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
          end
        end
      end

      ST_BUSY_IF: begin
        if (bus.mem_valid) begin
          state_d = ST_IDLE;
          if (!bus.if_flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else if (tmo_hit) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (bus.if_flush) begin
            state_d = ST_DROP;
          end
        end
      end

      ST_BUSY_D: begin
        if (bus.mem_valid) begin
          state_d   = ST_IDLE;
          d_valid_d = 1'b1;
          d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
        end else if (tmo_hit) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_DROP: begin
        // The flushed word is swallowed; only a timeout is reported from here.
        if (bus.mem_valid) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mask_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      timeout_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_mask_q  <= mem_mask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      timeout_q   <= timeout_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_mask  = mem_mask_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.timeout   = timeout_q;
  assign dbg_state_o   = state_q;

endmodule
